// File: rtl/key_duty_ctrl_if.sv
// ============================================================================
// Module      : key_duty_ctrl_if
// Description : Key inputs and duty/status outputs of the key duty controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_duty_ctrl_if #(
    parameter int WIDTH = 17
);
    logic             KEY0;
    logic             KEY1;
    logic [WIDTH-1:0] DUTY;
    logic             UP_STB;
    logic             DN_STB;
    logic [1:0]       KEY_STATE;

    modport master (
        output KEY0, KEY1,
        input  DUTY, UP_STB, DN_STB, KEY_STATE
    );

    modport slave (
        input  KEY0, KEY1,
        output DUTY, UP_STB, DN_STB, KEY_STATE
    );
endinterface

`default_nettype wire

// File: rtl/key_duty_ctrl.sv
// ============================================================================
// Module      : key_duty_ctrl
// Description : Two-button synchronise/debounce/auto-repeat front end that
//               steps a saturating PWM duty value up (KEY0) or down (KEY1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_duty_ctrl #(
    parameter int WIDTH         = 17,
    parameter int DUTY_RESET    = 1024,
    parameter int STEP          = 1,
    parameter int DEBOUNCE_CYC  = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  wire logic      CLK100MHZ,
    input  wire logic      RESET,
    key_duty_ctrl_if.slave bus
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int c_TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TM_W   = $clog2(c_TM_MAX);

    localparam logic [c_DB_W-1:0] c_DB_LAST     = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_TM_W-1:0] c_DELAY_LOAD  = c_TM_W'(REPEAT_DELAY - 1);
    localparam logic [c_TM_W-1:0] c_PERIOD_LOAD = c_TM_W'(REPEAT_PERIOD - 1);
    localparam logic [WIDTH-1:0]  c_DUTY_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  c_STEP        = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]  c_DUTY_RESET  = WIDTH'(DUTY_RESET);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [1:0] w_key_raw;
    logic [1:0] w_step;
    logic [1:0] w_key_state;

    assign w_key_raw = {bus.KEY1, bus.KEY0};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic              r_sync1;
        logic              r_sync2;
        logic              r_deb;      // debounced level, 1 = released
        logic [c_DB_W-1:0] r_db_cnt;
        logic              r_pressed;  // previous debounced state, doubles as KEY_STATE
        state_t            r_state;
        logic [c_TM_W-1:0] r_timer;
        logic              r_step;

        always_ff @(posedge CLK100MHZ) begin
            if (RESET) begin
                r_sync1   <= 1'b1;
                r_sync2   <= 1'b1;
                r_deb     <= 1'b1;
                r_db_cnt  <= '0;
                r_pressed <= 1'b0;
            end else begin
                r_sync1   <= w_key_raw[k];
                r_sync2   <= r_sync1;
                r_pressed <= ~r_deb;
                if (r_sync2 == r_deb) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_deb    <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        // Release is checked before timer expiry so a key let go on the
        // expiry cycle never produces a late step.
        always_ff @(posedge CLK100MHZ) begin
            if (RESET) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
                r_step  <= 1'b0;
            end else begin
                r_step <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_deb && !r_pressed) begin
                            r_step  <= 1'b1;
                            r_timer <= c_DELAY_LOAD;
                            r_state <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (r_deb) begin
                            r_timer <= '0;
                            r_state <= ST_IDLE;
                        end else if (r_timer == '0) begin
                            r_step  <= 1'b1;
                            r_timer <= c_PERIOD_LOAD;
                            r_state <= ST_REPEAT;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_deb) begin
                            r_timer <= '0;
                            r_state <= ST_IDLE;
                        end else if (r_timer == '0) begin
                            r_step  <= 1'b1;
                            r_timer <= c_PERIOD_LOAD;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    default: begin
                        r_timer <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign w_step[k]      = r_step;
        assign w_key_state[k] = r_pressed;
    end

    logic [WIDTH-1:0] r_duty;
    logic [WIDTH:0]   w_up_sum;

    // One extra bit catches the carry so the up step saturates instead of wrapping.
    assign w_up_sum = {1'b0, r_duty} + {1'b0, c_STEP};

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            r_duty <= c_DUTY_RESET;
        end else if (w_step[0] && !w_step[1]) begin
            r_duty <= w_up_sum[WIDTH] ? c_DUTY_MAX : w_up_sum[WIDTH-1:0];
        end else if (w_step[1] && !w_step[0]) begin
            r_duty <= (r_duty >= c_STEP) ? (r_duty - c_STEP) : '0;
        end
    end

    assign bus.DUTY      = r_duty;
    assign bus.UP_STB    = w_step[0];
    assign bus.DN_STB    = w_step[1];
    assign bus.KEY_STATE = w_key_state;

endmodule

`default_nettype wire
